cache_writeback_engine: RTL
===========================

Name: cache_writeback_engine

Overview:
- Read-side master for the cache data RAM: on request, reads one cache line (LINE_WORDS consecutive words) from the RAM's registered read port and streams it to the memory bus over a valid/ready interface.
- Sits between the cache controller (issues writeback requests on dirty eviction) and the memory-side write channel.
- Handles RAM read stalls (a RAM write in the same cycle suppresses the read) and memory backpressure with a 2-entry output buffer.

Parameters:
- DATA_WIDTH, 32, word width; multiple of 8; equals the RAM data width.
- ADDR_WIDTH, 5, RAM word-address width.
- LINE_WORDS, 4, words per line; power of 2, at least 2, at most 2^ADDR_WIDTH.
- MEM_ADDR_WIDTH, 32, memory byte-address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  writeback request.
- req_ready  out  1  engine idle; request accepted when req_valid && req_ready at posedge.
- req_ram_base  in  ADDR_WIDTH  RAM word address of line word 0.
- req_mem_addr  in  MEM_ADDR_WIDTH  memory byte address of line word 0.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_wr_en  in  1  RAM write enable from the cache write path; when high, the RAM performs no read that cycle.
- ram_rd_data  in  DATA_WIDTH  RAM registered read data.
- mem_valid  out  1  word valid toward memory.
- mem_ready  in  1  memory accepts the word.
- mem_addr  out  MEM_ADDR_WIDTH  byte address of the current word.
- mem_data  out  DATA_WIDTH  current word.
- mem_last  out  1  current word is the last of the line.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: clk, synchronous, active-high rst. State goes to IDLE, buffer is emptied, and all counters clear. Output reset values: req_ready=1, mem_valid=0, mem_last=0, mem_addr=0, mem_data=0, ram_rd_addr=0, done=0. A reset mid-burst aborts the burst silently: no done pulse and no further words.
- States: IDLE and RUN.
  - IDLE to RUN: on request handshake. req_ram_base and req_mem_addr are latched, and the issue and send indices clear.
  - RUN to IDLE: on the handshake of the word with mem_last=1. done is registered high in the following cycle.
  - req_ready = (state == IDLE).
- Read issue, in RUN: a read for issue index k is attempted when k < LINE_WORDS and (buffer count + reads in flight) < 2.
  - ram_rd_addr = base + k, modulo 2^ADDR_WIDTH (wraps).
  - The read succeeds only if ram_wr_en=0 in that cycle. On success, k increments and one read is in flight.
  - If ram_wr_en=1, the same address is reissued on the next cycle. No word is lost or duplicated.
- Read latency: 1 cycle. ram_rd_data is captured into the buffer in the cycle after a successful issue.
- Buffer: 2-entry FIFO of {data, index}.
  - mem_valid = buffer not empty. mem_data, mem_addr and mem_last come from the head entry and stay stable while mem_valid && !mem_ready.
  - mem_addr = req_mem_addr + index * (DATA_WIDTH/8), truncated to MEM_ADDR_WIDTH. No alignment check.
  - mem_last = (index == LINE_WORDS-1).
  - A capture and a pop in the same cycle are both performed; the count is unchanged.
- Throughput: 1 word/cycle when mem_ready=1 and ram_wr_en=0.
  - Request accepted at edge 0; first read issued in cycle 1; word 0 is valid in cycle 2.
  - Last word is valid in cycle LINE_WORDS+1; done is high in cycle LINE_WORDS+2; req_ready returns to 1 in the same cycle as done.
- A new request can be accepted in the cycle done is high (back-to-back bursts).
- req_valid is ignored while in RUN. mem_ready is ignored while mem_valid=0.

Test Plan:
- Basic burst, LINE_WORDS=4, base=8, mem_addr=0x1000, RAM[8..11]=A0..A3, mem_ready=1 -> words A0..A3 at 0x1000, 0x1004, 0x1008, 0x100C in cycles 2-5; mem_last only in cycle 5; done in cycle 6.
- Backpressure: same burst with mem_ready low for 3 cycles while word 1 is valid -> word 1 held stable; no more than 2 reads outstanding or buffered; output order A0..A3 exactly once each.
- Read collision: ram_wr_en=1 during the issue of index 2 for 2 cycles -> ram_rd_addr=10 held for 3 cycles; stream A0..A3 with no duplicate or gap; done delayed by 2 cycles.
- Wrap: base=30, RAM[30], RAM[31], RAM[0], RAM[1] = B0..B3 -> ram_rd_addr sequence 30, 31, 0, 1; data B0..B3 in order.
- Reset mid-burst: assert rst after word 1 handshake -> next cycle mem_valid=0, req_ready=1, no done; a new request then completes normally.
- Back-to-back: req_valid held high with a second line queued -> second request accepted in the done cycle; second stream starts 2 cycles later.

Source files
------------

// File: rtl/cache_writeback_engine_if.sv
// Signal bundle between the writeback engine, the cache data RAM read port,
// the cache controller request path and the memory-side write channel.
interface cache_writeback_engine_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned MEM_ADDR_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_WIDTH-1:0]     req_ram_base;
  logic [MEM_ADDR_WIDTH-1:0] req_mem_addr;
  logic [ADDR_WIDTH-1:0]     ram_rd_addr;
  logic                      ram_wr_en;
  logic [DATA_WIDTH-1:0]     ram_rd_data;
  logic                      mem_valid;
  logic                      mem_ready;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_data;
  logic                      mem_last;
  logic                      done;

  // Engine side
  modport master (
    input  req_valid, req_ram_base, req_mem_addr, ram_wr_en, ram_rd_data, mem_ready,
    output req_ready, ram_rd_addr, mem_valid, mem_addr, mem_data, mem_last, done
  );

  // Environment side (controller, RAM, memory)
  modport slave (
    output req_valid, req_ram_base, req_mem_addr, ram_wr_en, ram_rd_data, mem_ready,
    input  req_ready, ram_rd_addr, mem_valid, mem_addr, mem_data, mem_last, done
  );
endinterface

// File: rtl/cache_writeback_engine.sv
// Reads one cache line from the data RAM's registered read port and streams it
// to memory over valid/ready, tolerating RAM read stalls and memory backpressure.
module cache_writeback_engine #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned LINE_WORDS     = 4,
  parameter int unsigned MEM_ADDR_WIDTH = 32
) (
  input logic                      clk,
  input logic                      rst,
  cache_writeback_engine_if.master bus
);
  localparam int unsigned IdxW = $clog2(LINE_WORDS);
  localparam int unsigned CntW = IdxW + 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     ram_base_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_base_q;
  logic [CntW-1:0]           issue_q;
  logic                      fly_q;      // read issued last cycle, data on ram_rd_data now
  logic [IdxW-1:0]           fly_idx_q;
  logic [DATA_WIDTH-1:0]     buf_data_q [2];
  logic [IdxW-1:0]           buf_idx_q  [2];
  logic                      rd_ptr_q;
  logic                      wr_ptr_q;
  logic [1:0]                count_q;
  logic                      done_q;

  logic                  run;
  logic                  issue_ok;
  logic                  head_buf;
  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic [IdxW-1:0]       head_idx;
  logic                  pop;
  logic                  pop_buf;
  logic                  push;
  logic                  last_hs;

  // Issue/handshake decode; an in-flight word with an empty buffer is presented
  // straight from the RAM output so word 0 is valid one cycle after its read.
  always_comb begin
    run        = (state_q == StRun);
    issue_ok   = run && (issue_q < CntW'(LINE_WORDS)) &&
                 ((count_q + {1'b0, fly_q}) < 2'd2) && !bus.ram_wr_en;
    head_buf   = (count_q != 2'd0);
    head_valid = head_buf || fly_q;
    head_data  = head_buf ? buf_data_q[rd_ptr_q] : bus.ram_rd_data;
    head_idx   = head_buf ? buf_idx_q[rd_ptr_q] : fly_idx_q;
    pop        = head_valid && bus.mem_ready;
    pop_buf    = head_buf && bus.mem_ready;
    // In-flight word is stored unless it bypasses directly to memory
    push       = fly_q && (head_buf || !bus.mem_ready);
    last_hs    = pop && (head_idx == IdxW'(LINE_WORDS - 1));
  end

  // Output drive; all-zero whenever nothing is valid
  always_comb begin
    bus.req_ready   = !run;
    bus.ram_rd_addr = run ? ram_base_q + ADDR_WIDTH'(issue_q) : '0;
    bus.mem_valid   = head_valid;
    bus.mem_data    = head_valid ? head_data : '0;
    bus.mem_addr    = head_valid ?
                      mem_base_q + MEM_ADDR_WIDTH'(head_idx) * MEM_ADDR_WIDTH'(DATA_WIDTH / 8) :
                      '0;
    bus.mem_last    = head_valid && (head_idx == IdxW'(LINE_WORDS - 1));
    bus.done        = done_q;
  end

  // FSM, read issue, output FIFO and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ram_base_q    <= '0;
      mem_base_q    <= '0;
      issue_q       <= '0;
      fly_q         <= 1'b0;
      fly_idx_q     <= '0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_idx_q[0]  <= '0;
      buf_idx_q[1]  <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= last_hs;
      fly_q  <= issue_ok;
      if (issue_ok) begin
        issue_q   <= issue_q + CntW'(1);
        fly_idx_q <= IdxW'(issue_q);
      end
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.ram_rd_data;
        buf_idx_q[wr_ptr_q]  <= fly_idx_q;
        wr_ptr_q             <= !wr_ptr_q;
      end
      if (pop_buf) rd_ptr_q <= !rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop_buf);

      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            state_q    <= StRun;
            ram_base_q <= bus.req_ram_base;
            mem_base_q <= bus.req_mem_addr;
            issue_q    <= '0;
          end
        end
        StRun: begin
          if (last_hs) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
